// File: rtl/ascon_decrypt_core.sv
// ASCON-128 decryption core: iterative permutation, one round per clock, with
// 64-bit ciphertext blocks consumed through a valid/ready handshake.
module ascon_decrypt_core (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [63:0]  ad_i,
  input  logic [127:0] tag_i,
  input  logic [63:0]  c_i,
  input  logic         c_valid_i,
  input  logic         c_last_i,
  output logic         c_ready_o,
  output logic [63:0]  p_o,
  output logic         p_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         auth_ok_o,
  output logic [127:0] tag_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD, S_WAIT_C, S_CT_PERM, S_FINAL, S_DONE
  } fsm_t;

  typedef logic [4:0][63:0] st_t;

  localparam logic [63:0] IV  = 64'h80400c0600000000;
  localparam logic [63:0] PAD = 64'h8000000000000000;

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   rnd, rnd_nxt;
  st_t          x_p0, rin, rout;
  logic [127:0] key_q, tag_q;
  logic [63:0]  ad_q;
  logic         last_q;
  logic         load, hs, step;
  logic [63:0]  p_p1;
  logic         vld_p1;
  logic [127:0] tag_p1;
  logic         auth_p1;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Constant addition, bitsliced S-box, then the per-word linear diffusion.
  function automatic st_t asc_round(input st_t s, input logic [3:0] r);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    st_t o;
    a0 = s[0];
    a1 = s[1];
    a2 = s[2] ^ {56'd0, ~r, r};
    a3 = s[3];
    a4 = s[4];
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    o[0] = a0 ^ ror64(a0, 19) ^ ror64(a0, 28);
    o[1] = a1 ^ ror64(a1, 61) ^ ror64(a1, 39);
    o[2] = a2 ^ ror64(a2, 1)  ^ ror64(a2, 6);
    o[3] = a3 ^ ror64(a3, 10) ^ ror64(a3, 17);
    o[4] = a4 ^ ror64(a4, 7)  ^ ror64(a4, 41);
    return o;
  endfunction

  always_comb begin
    fsm_nxt = fsm;
    rnd_nxt = rnd;
    load    = 1'b0;
    hs      = 1'b0;
    case (fsm)
      S_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          fsm_nxt = S_INIT;
          rnd_nxt = 4'd0;
        end
      end
      S_INIT: begin
        if (rnd == 4'd11) begin
          fsm_nxt = S_AD;
          rnd_nxt = 4'd6;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      S_AD: begin
        if (rnd == 4'd11) begin
          fsm_nxt = S_WAIT_C;
          rnd_nxt = 4'd6;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      S_WAIT_C: begin
        if (c_valid_i) begin
          hs      = 1'b1;
          fsm_nxt = S_CT_PERM;
          rnd_nxt = 4'd7;
        end
      end
      S_CT_PERM: begin
        if (rnd == 4'd11) begin
          fsm_nxt = last_q ? S_FINAL : S_WAIT_C;
          rnd_nxt = last_q ? 4'd0 : 4'd6;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      S_FINAL: begin
        if (rnd == 4'd11) begin
          fsm_nxt = S_DONE;
          rnd_nxt = 4'd0;
        end else begin
          rnd_nxt = rnd + 4'd1;
        end
      end
      S_DONE: begin
        fsm_nxt = S_IDLE;
        rnd_nxt = 4'd0;
      end
      default: begin
        fsm_nxt = S_IDLE;
        rnd_nxt = 4'd0;
      end
    endcase
  end

  assign step = hs || (fsm == S_INIT) || (fsm == S_AD) ||
                (fsm == S_CT_PERM) || (fsm == S_FINAL);

  // Round input injection, the round itself, then the round-11 output XORs.
  always_comb begin
    rin = x_p0;
    case (fsm)
      S_AD:     if (rnd == 4'd6) rin[0] = x_p0[0] ^ ad_q;
      S_WAIT_C: rin[0] = c_i;
      S_FINAL: begin
        if (rnd == 4'd0) begin
          rin[0] = x_p0[0] ^ PAD;
          rin[1] = x_p0[1] ^ key_q[127:64];
          rin[2] = x_p0[2] ^ key_q[63:0];
        end
      end
      default: ;
    endcase
    rout = asc_round(rin, rnd);
    if (rnd == 4'd11) begin
      if ((fsm == S_INIT) || (fsm == S_FINAL)) begin
        rout[3] = rout[3] ^ key_q[127:64];
        rout[4] = rout[4] ^ key_q[63:0];
      end
      if (fsm == S_AD) rout[4] = rout[4] ^ 64'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm     <= S_IDLE;
      rnd     <= 4'd0;
      x_p0    <= '0;
      key_q   <= '0;
      tag_q   <= '0;
      ad_q    <= '0;
      last_q  <= 1'b0;
      p_p1    <= '0;
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      auth_p1 <= 1'b0;
    end else begin
      fsm    <= fsm_nxt;
      rnd    <= rnd_nxt;
      vld_p1 <= hs;
      if (load) begin
        x_p0    <= {nonce_i[63:0], nonce_i[127:64], key_i[63:0], key_i[127:64], IV};
        key_q   <= key_i;
        tag_q   <= tag_i;
        ad_q    <= ad_i;
        tag_p1  <= '0;
        auth_p1 <= 1'b0;
      end else if (step) begin
        x_p0 <= rout;
      end
      if (hs) begin
        p_p1   <= x_p0[0] ^ c_i;
        last_q <= c_last_i;
      end
      if ((fsm == S_FINAL) && (rnd == 4'd11)) begin
        tag_p1  <= {rout[3], rout[4]};
        auth_p1 <= ({rout[3], rout[4]} == tag_q);
      end
      if (fsm == S_DONE) auth_p1 <= 1'b0;
    end
  end

  assign c_ready_o = (fsm == S_WAIT_C);
  assign busy_o    = (fsm != S_IDLE);
  assign done_o    = (fsm == S_DONE);
  assign p_o       = p_p1;
  assign p_valid_o = vld_p1;
  assign tag_o     = tag_p1;
  assign auth_ok_o = auth_p1;

endmodule

// File: doc/ascon_decrypt_core.md
ASCON_DECRYPT_CORE -- requirements
Module: ascon_decrypt_core

Interface
REQ-001 SHALL have port: clock_i  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: reset_i  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port: start_i  input  1  one-cycle request that samples key_i, nonce_i, ad_i and tag_i; honoured only in IDLE.
REQ-004 SHALL have ports: key_i  input  128  key; nonce_i  input  128  nonce; ad_i  input  64  single pre-padded associated-data block; tag_i  input  128  expected tag.
REQ-005 SHALL have ports: c_i  input  64  ciphertext block; c_valid_i  input  1  block valid; c_last_i  input  1  final full block; c_ready_o  output  1  block accepted when c_valid_i and c_ready_o are both high.
REQ-006 SHALL have ports: p_o  output  64  plaintext; p_valid_o  output  1  one-cycle plaintext strobe, no backpressure.
REQ-007 SHALL have ports: busy_o  output  1  not IDLE; done_o  output  1  one-cycle completion pulse; auth_ok_o  output  1  tag match, valid while done_o is high; tag_o  output  128  computed tag.

Function
REQ-008 SHALL implement ASCON-128 decryption iteratively: 320-bit state x0..x4, one round per cycle (constant addition, 5-bit S-box, linear diffusion), with a 4-bit round counter.
REQ-009 SHALL use round constant ((15-r)<<4)|r for round r: p12 runs r=0..11, p6 runs r=6..11.
REQ-010 SHALL follow the FSM IDLE -> INIT -> AD -> WAIT_C -> CT_PERM -> (WAIT_C | FINAL) -> DONE -> IDLE.
REQ-011 SHALL, on start_i in IDLE (cycle T), load x0=64'h80400c0600000000, x1||x2=key_i, x3||x4=nonce_i, and latch key_i and tag_i.
REQ-012 INIT SHALL run p12 in cycles T+1..T+12; the round-11 update also XORs the key into x3||x4.
REQ-013 AD SHALL run p6 in cycles T+13..T+18: x0 ^= ad_i at the input of round 6, x4 ^= 64'h1 at the output of round 11.
REQ-014 WAIT_C SHALL assert c_ready_o, first in cycle T+19; c_ready_o SHALL be low in every other state.
REQ-015 On a handshake in cycle t: P = x0 ^ c_i; p_o = P and p_valid_o = 1 in cycle t+1; round 6 runs in cycle t with x0 replaced by c_i; rounds 7..11 run in CT_PERM at t+1..t+5; if c_last_i is low, return to WAIT_C at t+6.
REQ-016 If c_last_i is high at the handshake, after round 11 SHALL enter FINAL and run p12 (12 cycles): at round-0 input x0 ^= 64'h8000000000000000 (implicit empty padding block) and x1||x2 ^= key; at round-11 output x3||x4 ^= key.
REQ-017 DONE (one cycle) SHALL assert done_o, drive tag_o = x3||x4 and auth_ok_o = (x3||x4 == tag_i), then return to IDLE; tag_o holds until the next start.
REQ-018 start_i outside IDLE SHALL be ignored; c_valid_i outside WAIT_C SHALL be ignored and no block consumed.
REQ-019 Plaintext SHALL be released before authentication; auth_ok_o=0 marks all released plaintext invalid. At least one ciphertext block per message; empty messages are out of scope.
REQ-020 Round counter SHALL stay at 4 bits, counting 0..11 or 6..11, and never wrap past 11.

Reset
REQ-021 reset_i high at a rising edge SHALL force IDLE from any state, including mid-permutation, and clear state, counter, latched key/tag and all outputs (c_ready_o, p_valid_o, done_o, auth_ok_o, busy_o = 0; p_o, tag_o = 0).
REQ-022 The first start_i accepted SHALL be the one sampled in the first cycle after reset_i is released.
REQ-023 reset_i and start_i high together SHALL give reset priority.

Verification
REQ-024 start at T, c_valid_i held high -> busy_o=1 from T+1; c_ready_o first high at T+19; rounds seen in order 0..11, 6..11 with constants 0xf0, 0x96, 0x4b at r=0, 6, 11.
REQ-025 Encrypt with the team C model (key 000102..0f, nonce 101112..1f, ad 3230323300000000, 3 blocks), feed the ciphertext with a correct tag -> p_o matches the plaintext blocks in order, done_o 12 cycles after the last CT_PERM, auth_ok_o=1, tag_o equals the model tag.
REQ-026 Same message with tag_i bit 0 flipped -> plaintext identical to REQ-025, auth_ok_o=0, tag_o unchanged.
REQ-027 c_valid_i low for 10 cycles in WAIT_C, then a pulse -> state frozen, c_ready_o held high, exactly one p_valid_o; extra start_i pulses while busy are ignored.
REQ-028 reset_i asserted at FINAL round 5 -> next cycle all outputs 0 and IDLE; a fresh REQ-025 run then passes.
